// File: rtl/fetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_buffer
// Description : Instruction fetch stage. It owns the fetch PC and issues
//               in-order word requests to a pipelined instruction memory over
//               a valid/ready channel. Returned words are buffered with their
//               PCs in a DEPTH-entry FIFO that decode drains over valid/ready.
//               A redirect flushes the FIFO, drops every in-flight response
//               and restarts fetch at the new PC.
// Ports       : i_clk, i_srst            clock, synchronous active-high reset
//               o_imemReqValid/Addr,
//               i_imemReqReady           memory request channel
//               i_imemRspValid/Data      in-order memory responses
//               i_redirectValid/Pc       flush and restart
//               o_instrValid/o_instr/
//               o_instrPc, i_instrReady  decode handshake (FIFO head)
//               o_misaligned             sticky misaligned-redirect flag
// Config      : FETCH_ALIGN_CHECK_EN - when defined, a redirect to a PC with
//               non-zero bits [1:0] sets o_misaligned and halts requests until
//               an aligned redirect or reset. When undefined, the low PC bits
//               are forced to zero and o_misaligned is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_srst,
  output logic        o_imemReqValid,
  input  logic        i_imemReqReady,
  output logic [31:0] o_imemReqAddr,
  input  logic        i_imemRspValid,
  input  logic [31:0] i_imemRspData,
  input  logic        i_redirectValid,
  input  logic [31:0] i_redirectPc,
  output logic        o_instrValid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instrPc,
  input  logic        i_instrReady,
  output logic        o_misaligned
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW      = PW + 1;
  localparam logic [CW:0]   C_DEPTH = (CW+1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_in_flight;
  logic [CW-1:0] r_discard;
  logic [PW-1:0] r_tag_rd;
  logic [PW-1:0] r_tag_wr;
  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_tag_mem   [DEPTH];

  logic          w_halted;
  logic          w_credit_ok;
  logic          w_req_fire;
  logic          w_rsp_ok;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_in_flight_next;
  logic [31:0]   w_redirect_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misaligned;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_misaligned <= 1'b0;
    end else if (i_redirectValid) begin
      r_misaligned <= |i_redirectPc[1:0];
    end
  end

  assign w_halted     = r_misaligned;
  assign o_misaligned = r_misaligned;
`else
  logic w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^i_redirectPc[1:0];
  assign w_halted         = 1'b0;
  assign o_misaligned     = 1'b0;
`endif

  // Credit rule: buffered plus outstanding words never exceed DEPTH, so every
  // response is guaranteed a FIFO slot and the tag queue never overflows.
  assign w_credit_ok    = ({1'b0, r_count} + {1'b0, r_in_flight}) < C_DEPTH;
  assign o_imemReqValid = !i_srst && w_credit_ok && !w_halted;
  assign o_imemReqAddr  = r_fetch_pc;
  assign w_req_fire     = o_imemReqValid && i_imemReqReady;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_ok = i_imemRspValid && (r_in_flight != '0);
  assign w_push   = w_rsp_ok && (r_discard == '0) && !i_redirectValid;
  assign w_pop    = (r_count != '0) && i_instrReady && !i_redirectValid;

  assign w_in_flight_next = r_in_flight + CW'(w_req_fire) - CW'(w_rsp_ok);
  assign w_redirect_pc    = {i_redirectPc[31:2], 2'b00};

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_fetch_pc  <= RESET_PC;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_in_flight <= '0;
      r_discard   <= '0;
      r_tag_rd    <= '0;
      r_tag_wr    <= '0;
    end else begin
      r_in_flight <= w_in_flight_next;
      if (w_req_fire) begin
        r_tag_wr <= r_tag_wr + PW'(1);
      end
      if (w_rsp_ok) begin
        r_tag_rd <= r_tag_rd + PW'(1);
      end
      if (i_redirectValid) begin
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_fetch_pc <= w_redirect_pc;
        // Every request still outstanding after this cycle belongs to the
        // old stream (including one issued this cycle), so all of them are
        // dropped. Any previous discard backlog is a subset of in-flight and
        // must not be counted twice.
        r_discard  <= w_in_flight_next;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_rsp_ok && (r_discard != '0)) begin
          r_discard <= r_discard - CW'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Storage arrays need no reset: occupancy is governed by the counters.
  always_ff @(posedge i_clk) begin
    if (w_req_fire) begin
      r_tag_mem[r_tag_wr] <= r_fetch_pc;
    end
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= i_imemRspData;
      r_pc_mem[r_wr_ptr]    <= r_tag_mem[r_tag_rd];
    end
  end

  // Head outputs are gated by occupancy so an empty FIFO presents zeros.
  assign o_instrValid = (r_count != '0);
  assign o_instr      = o_instrValid ? r_instr_mem[r_rd_ptr] : 32'h0;
  assign o_instrPc    = o_instrValid ? r_pc_mem[r_rd_ptr]    : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_buffer
// Description : Directed self-checking bench for fetch_prefetch_buffer with a
//               small pipelined instruction-memory model (fixed latency, word
//               data = address ^ 32'hDEAD_BEEF). Honours FETCH_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_buffer;

  logic        i_clk = 1'b0;
  logic        i_srst = 1'b1;
  logic        i_imemReqReady = 1'b0;
  logic        i_imemRspValid = 1'b0;
  logic [31:0] i_imemRspData = 32'h0;
  logic        i_redirectValid = 1'b0;
  logic [31:0] i_redirectPc = 32'h0;
  logic        i_instrReady = 1'b0;
  logic        o_imemReqValid;
  logic [31:0] o_imemReqAddr;
  logic        o_instrValid;
  logic [31:0] o_instr;
  logic [31:0] o_instrPc;
  logic        o_misaligned;

  always #5 i_clk = ~i_clk;

  fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .i_clk          (i_clk),
    .i_srst         (i_srst),
    .o_imemReqValid (o_imemReqValid),
    .i_imemReqReady (i_imemReqReady),
    .o_imemReqAddr  (o_imemReqAddr),
    .i_imemRspValid (i_imemRspValid),
    .i_imemRspData  (i_imemRspData),
    .i_redirectValid(i_redirectValid),
    .i_redirectPc   (i_redirectPc),
    .o_instrValid   (o_instrValid),
    .o_instr        (o_instr),
    .o_instrPc      (o_instrPc),
    .i_instrReady   (i_instrReady),
    .o_misaligned   (o_misaligned)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int rel_edge = 0;
  int mem_lat = 1;
  bit mem_rdy = 1'b1;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];
  int          pop_edge[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: memory model drives response/ready for the coming edge,
  // request and pop handshakes are logged, then the edge is taken.
  task automatic cycle();
    i_imemRspValid = 1'b0;
    i_imemRspData  = 32'h0;
    if (mq_due.size() > 0 && mq_due[0] <= edge_n + 1) begin
      i_imemRspValid = 1'b1;
      i_imemRspData  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    i_imemReqReady = mem_rdy;
    #1;
    if (o_imemReqValid && i_imemReqReady) begin
      mq_addr.push_back(o_imemReqAddr);
      mq_due.push_back(edge_n + 1 + mem_lat);
      req_log.push_back(o_imemReqAddr);
    end
    if (o_instrValid && i_instrReady) begin
      pop_pc.push_back(o_instrPc);
      pop_ins.push_back(o_instr);
      pop_edge.push_back(edge_n + 1);
    end
    @(posedge i_clk);
    edge_n++;
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc.delete();
    pop_ins.delete();
    pop_edge.delete();
  endtask

  task automatic do_reset(input int lat, input bit dec_rdy);
    i_srst = 1'b1;
    i_redirectValid = 1'b0;
    i_instrReady = dec_rdy;
    mem_lat = lat;
    mem_rdy = 1'b1;
    cycle();
    cycle();
    mq_addr.delete();
    mq_due.delete();
    clear_logs();
    i_srst = 1'b0;
    rel_edge = edge_n;
  endtask

  task automatic run_pops(input int n, input string tag);
    int k = 0;
    while (pop_pc.size() < n && k < 40) begin
      cycle();
      k++;
    end
    check({tag, "_npops"}, 32'(pop_pc.size()), 32'(n));
  endtask

  task automatic redirect(input logic [31:0] pc);
    i_redirectValid = 1'b1;
    i_redirectPc = pc;
    cycle();
    i_redirectValid = 1'b0;
    clear_logs();
  endtask

  initial begin
    // ---- Reset state and basic streaming, L=1 --------------------------
    i_srst = 1'b1;
    i_instrReady = 1'b1;
    cycle();
    cycle();
    check("rst_reqvalid", 32'(o_imemReqValid), 32'd0);
    check("rst_ivalid", 32'(o_instrValid), 32'd0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_ipc", o_instrPc, 32'h0);
    check("rst_misal", 32'(o_misaligned), 32'd0);
    do_reset(1, 1'b1);
    #0;
    check("first_reqvalid", 32'(o_imemReqValid), 32'd1);
    check("first_reqaddr", o_imemReqAddr, 32'h0);
    run_pops(4, "t1");
    if (pop_pc.size() >= 4) begin
      check("t1_lat", 32'(pop_edge[0] - rel_edge), 32'd3);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t1_pc%0d", i), pop_pc[i], 32'(4 * i));
        check($sformatf("t1_ins%0d", i), pop_ins[i], mem_word(32'(4 * i)));
        check($sformatf("t1_edge%0d", i), 32'(pop_edge[i] - pop_edge[0]), 32'(i));
      end
    end

    // ---- Backpressure, L=2 ---------------------------------------------
    do_reset(2, 1'b0);
    for (int i = 0; i < 12; i++) cycle();
    check("t2_nreq", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < req_log.size(); i++)
      check($sformatf("t2_req%0d", i), req_log[i], 32'(4 * i));
    check("t2_reqvalid_off", 32'(o_imemReqValid), 32'd0);
    check("t2_head_pc", o_instrPc, 32'h0);
    i_instrReady = 1'b1;
    run_pops(5, "t2");
    for (int i = 0; i < 5 && i < pop_pc.size(); i++)
      check($sformatf("t2_pc%0d", i), pop_pc[i], 32'(4 * i));
    if (req_log.size() > 4) check("t2_resume", req_log[4], 32'h10);

    // ---- Redirect with requests in flight, L=3 -------------------------
    do_reset(3, 1'b1);
    cycle();
    cycle();
    check("t3_inflight_nopop", 32'(pop_pc.size()), 32'd0);
    redirect(32'h100);
    check("t3_reqaddr", o_imemReqAddr, 32'h100);
    run_pops(2, "t3");
    if (pop_pc.size() >= 2) begin
      check("t3_pc0", pop_pc[0], 32'h100);
      check("t3_ins0", pop_ins[0], mem_word(32'h100));
      check("t3_pc1", pop_pc[1], 32'h104);
    end

    // ---- Redirect coincident with response and pop ---------------------
    do_reset(1, 1'b0);
    for (int k = 0; k < 20 && req_log.size() < 4; k++) cycle();
    check("t4_head_pc", o_instrPc, 32'h0);
    i_instrReady = 1'b1;
    redirect(32'h300);
    check("t4_empty", 32'(o_instrValid), 32'd0);
    check("t4_reqaddr", o_imemReqAddr, 32'h300);
    run_pops(2, "t4");
    if (pop_pc.size() >= 2) begin
      check("t4_pc0", pop_pc[0], 32'h300);
      check("t4_ins0", pop_ins[0], mem_word(32'h300));
      check("t4_pc1", pop_pc[1], 32'h304);
    end

    // ---- Address wrap --------------------------------------------------
    do_reset(1, 1'b1);
    redirect(32'hFFFF_FFF8);
    run_pops(3, "t5");
    if (req_log.size() >= 3 && pop_pc.size() >= 3) begin
      check("t5_req0", req_log[0], 32'hFFFF_FFF8);
      check("t5_req1", req_log[1], 32'hFFFF_FFFC);
      check("t5_req2", req_log[2], 32'h0000_0000);
      check("t5_pc2", pop_pc[2], 32'h0000_0000);
      check("t5_ins1", pop_ins[1], mem_word(32'hFFFF_FFFC));
    end

    // ---- Misaligned redirect -------------------------------------------
    do_reset(1, 1'b1);
    redirect(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    check("t6_misal_set", 32'(o_misaligned), 32'd1);
    check("t6_halt", 32'(o_imemReqValid), 32'd0);
    for (int i = 0; i < 5; i++) cycle();
    check("t6_noreq", 32'(req_log.size()), 32'd0);
    check("t6_nostale", 32'(o_instrValid), 32'd0);
    redirect(32'h200);
    check("t6_misal_clr", 32'(o_misaligned), 32'd0);
    check("t6_reqaddr", o_imemReqAddr, 32'h200);
    run_pops(1, "t6");
    if (pop_pc.size() >= 1) check("t6_pc0", pop_pc[0], 32'h200);
`else
    check("t6_misal", 32'(o_misaligned), 32'd0);
    check("t6_reqvalid", 32'(o_imemReqValid), 32'd1);
    check("t6_reqaddr", o_imemReqAddr, 32'h100);
    run_pops(1, "t6");
    if (pop_pc.size() >= 1) check("t6_pc0", pop_pc[0], 32'h100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
